// File: rtl/muldiv_unit.sv
// muldiv_unit: HI/LO multiply/divide unit with fixed-latency operations,
// multiply-accumulate, direct HI/LO writes, and a one-deep HI/LO snapshot
// that restore rolls back to.
//
// Handshake: start is a one-cycle request that is only taken while busy=0.
// An accepted multi-cycle op holds busy=1 for exactly its latency, then busy
// drops and done pulses for one cycle. mthi/mtlo complete at the accepting
// edge and never raise busy or done. flush/restore cancel whatever is in
// flight and override start on the same edge.
module muldiv_unit #(
  parameter int W       = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  input  logic         restore,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         dbg_state
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [3:0]     r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_hi;
  logic [W-1:0]   r_lo;
  logic [W-1:0]   r_pre_hi;
  logic [W-1:0]   r_pre_lo;
  logic           r_done;

  logic           w_is_mul;
  logic           w_is_div;
  logic           w_cancel;
  logic           w_accept;
  logic           w_last;
  logic           w_commit;
  logic           w_wr;
  logic [2*W-1:0] w_cur;
  logic [2*W-1:0] w_res;
  logic [2*W-1:0] w_prod_s;
  logic [2*W-1:0] w_prod_u;
  logic           w_a_neg;
  logic           w_b_neg;
  logic [W-1:0]   w_num;
  logic [W-1:0]   w_den;
  logic [W-1:0]   w_den_safe;
  logic [W-1:0]   w_q_u;
  logic [W-1:0]   w_r_u;
  logic [W-1:0]   w_quo_s;
  logic [W-1:0]   w_rem_s;

  // Request decode and the cancel/accept/commit qualifiers.
  always_comb begin
    w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_cancel = flush || restore;
    w_accept = (r_state == S_IDLE) && start && !w_cancel;
    w_last   = (r_state == S_BUSY) && (r_cnt == CW'(1));
    w_commit = w_last && !w_cancel;
  end

  // Arithmetic on the latched operands. Signed division runs on magnitudes
  // so the most-negative / -1 case falls out naturally (quotient wraps to
  // itself, remainder 0). A zero divisor is steered to 1 only to keep the
  // divider defined; its result is discarded.
  always_comb begin
    w_cur      = {r_hi, r_lo};
    w_prod_s   = {{W{r_a[W-1]}}, r_a} * {{W{r_b[W-1]}}, r_b};
    w_prod_u   = {{W{1'b0}}, r_a} * {{W{1'b0}}, r_b};
    w_a_neg    = (r_op == OP_DIV) && r_a[W-1];
    w_b_neg    = (r_op == OP_DIV) && r_b[W-1];
    w_num      = w_a_neg ? -r_a : r_a;
    w_den      = w_b_neg ? -r_b : r_b;
    w_den_safe = (w_den == '0) ? W'(1) : w_den;
    w_q_u      = w_num / w_den_safe;
    w_r_u      = w_num % w_den_safe;
    w_quo_s    = (w_a_neg ^ w_b_neg) ? -w_q_u : w_q_u;
    w_rem_s    = w_a_neg ? -w_r_u : w_r_u;
  end

  // Commit value and write enable for the op that is finishing.
  always_comb begin
    w_res = w_cur;
    w_wr  = 1'b1;
    case (r_op)
      OP_MULT:  w_res = w_prod_s;
      OP_MULTU: w_res = w_prod_u;
      OP_MADD:  w_res = w_cur + w_prod_s;
      OP_MADDU: w_res = w_cur + w_prod_u;
      OP_MSUB:  w_res = w_cur - w_prod_s;
      OP_MSUBU: w_res = w_cur - w_prod_u;
      OP_DIV, OP_DIVU: begin
        if (r_b == '0) w_wr = 1'b0;
        else           w_res = {w_rem_s, w_quo_s};
      end
      default:  w_wr = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state: leave IDLE on a multi-cycle accept, leave BUSY on cancel
  // or on the final countdown edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept && (w_is_mul || w_is_div)) w_next = S_BUSY;
      S_BUSY: if (w_cancel || w_last)                 w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs and register views.
  always_comb begin
    busy      = (r_state == S_BUSY);
    dbg_state = r_state;
    done      = r_done;
    hi        = r_hi;
    lo        = r_lo;
  end

  // Datapath: HI/LO, snapshot, operand latches, countdown and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_pre_hi <= '0;
      r_pre_lo <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_cancel) begin
        r_cnt <= '0;
        if (restore) begin
          r_hi <= r_pre_hi;
          r_lo <= r_pre_lo;
        end
      end else if (w_accept) begin
        if (op == OP_MTHI) begin
          r_pre_hi <= r_hi;
          r_pre_lo <= r_lo;
          r_hi     <= a;
        end else if (op == OP_MTLO) begin
          r_pre_hi <= r_hi;
          r_pre_lo <= r_lo;
          r_lo     <= a;
        end else if (w_is_mul || w_is_div) begin
          r_op  <= op;
          r_a   <= a;
          r_b   <= b;
          r_cnt <= w_is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
        end
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_last && w_wr) begin
          r_pre_hi     <= r_hi;
          r_pre_lo     <= r_lo;
          {r_hi, r_lo} <= w_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit at default parameters (W=32,
// MUL_LAT=5, DIV_LAT=10) with hand-computed expected HI/LO values.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         restore;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [2*W-1:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  muldiv_unit #(.W(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .restore(restore), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // Advance one edge and sample 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: present one request for exactly one edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 4'd0; a = '0; b = '0;
  endtask

  // Multi-cycle op: count busy and done samples over a fixed window, then
  // compare against the scoreboard entry.
  task automatic run(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int lat, input logic [2*W-1:0] exp);
    int nb;
    int nd;
    logic [2*W-1:0] e;
    nb = 0; nd = 0;
    exp_q.push_back(exp);
    issue(o, x, y);
    check({tag, "_state"}, 64'(dbg_state), 64'd1);
    for (int i = 0; i < 16; i++) begin
      if (busy) nb++;
      if (done) nd++;
      tick();
    end
    e = exp_q.pop_front();
    check({tag, "_busy_cycles"}, 64'(nb), 64'(lat));
    check({tag, "_done_pulses"}, 64'(nd), 64'd1);
    check({tag, "_hilo"}, {hi, lo}, e);
  endtask

  task automatic set_hilo(input logic [W-1:0] h, input logic [W-1:0] l);
    issue(4'd5, h, '0);
    issue(4'd6, l, '0);
  endtask

  initial begin : main
    int nd;
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    flush = 1'b0; restore = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_busy_done", {62'd0, busy, done}, 64'd0);

    run("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 64'hFFFF_FFFF_FFFF_FFFA);
    run("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 64'hFFFF_FFFE_0000_0001);
    run("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 64'hFFFF_FFFF_FFFF_FFFD);
    run("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 64'h0000_0000_8000_0000);
    run("div_negb", 4'd3, 32'd7, 32'hFFFF_FFFE, 10, 64'h0000_0001_FFFF_FFFD);
    run("divu", 4'd4, 32'd100, 32'd7, 10, 64'h0000_0002_0000_000E);

    issue(4'd5, 32'd1, '0);
    check("mthi_hi", 64'(hi), 64'd1);
    check("mthi_busy_done", {62'd0, busy, done}, 64'd0);
    issue(4'd6, 32'd2, '0);
    check("mtlo_hilo", {hi, lo}, 64'h0000_0001_0000_0002);
    run("divu_zero", 4'd4, 32'd55, 32'd0, 10, 64'h0000_0001_0000_0002);

    set_hilo(32'd0, 32'hFFFF_FFFF);
    run("maddu", 4'd8, 32'd1, 32'd1, 5, 64'h0000_0001_0000_0000);
    run("msubu", 4'd10, 32'd1, 32'd1, 5, 64'h0000_0000_FFFF_FFFF);
    run("msub", 4'd9, 32'hFFFF_FFFF, 32'd1, 5, 64'h0000_0001_0000_0000);

    issue(4'd5, 32'd5, '0);
    issue(4'd5, 32'h1234, '0);
    check("mthi_1234", {hi, lo}, 64'h0000_1234_0000_0000);
    restore = 1'b1; tick(); restore = 1'b0;
    check("restore_hilo", {hi, lo}, 64'h0000_0005_0000_0000);

    issue(4'd12, 32'd9, 32'd9);
    check("illegal_busy", 64'(busy), 64'd0);
    issue(4'd0, 32'd9, 32'd9);
    check("none_hilo", {hi, lo}, 64'h0000_0005_0000_0000);

    // Flush in the third busy cycle.
    issue(4'd1, 32'd2, 32'd3);
    tick(); tick();
    check("pre_flush_busy", 64'(busy), 64'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      tick();
    end
    check("flush_no_done", 64'(nd), 64'd0);
    check("flush_hilo", {hi, lo}, 64'h0000_0005_0000_0000);

    // Flush on the commit edge wins.
    issue(4'd1, 32'd2, 32'd3);
    tick(); tick(); tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("flush_commit_busy_done", {62'd0, busy, done}, 64'd0);
    check("flush_commit_hilo", {hi, lo}, 64'h0000_0005_0000_0000);

    // Start while busy is ignored.
    issue(4'd1, 32'd2, 32'd3);
    tick();
    issue(4'd5, 32'hDEAD, '0);
    check("ignored_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++) tick();
    check("ignored_hilo", {hi, lo}, 64'h0000_0000_0000_0006);
    restore = 1'b1; tick(); restore = 1'b0;
    check("restore_after_commit", {hi, lo}, 64'h0000_0005_0000_0000);

    // Reset mid-operation.
    issue(4'd1, 32'd2, 32'd3);
    tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("midreset_hilo", {hi, lo}, 64'd0);
    check("midreset_busy_done", {62'd0, busy, done}, 64'd0);
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) nd++;
      tick();
    end
    check("midreset_no_done", 64'(nd), 64'd0);
    issue(4'd5, 32'd7, '0);
    restore = 1'b1; tick(); restore = 1'b0;
    check("reset_snapshot", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
